// File: rtl/pipe_hazard_scoreboard_if.sv
// rtl/pipe_hazard_scoreboard_if.sv - ID-stage hazard/forwarding bus between pipeline control and scoreboard
interface pipe_hazard_scoreboard_if #(
  parameter int REG_AW = 4,
  parameter int SEL_W  = 2,
  parameter int CNT_W  = 32
);
  logic              fwd_en;
  logic              ext_freeze;
  logic              flush;
  logic              id_valid;
  logic [REG_AW-1:0] id_src1;
  logic [REG_AW-1:0] id_src2;
  logic              id_src1_used;
  logic              id_src2_used;
  logic              id_wb_en;
  logic              id_mem_r_en;
  logic [REG_AW-1:0] id_dest;
  logic              stall;
  logic [SEL_W-1:0]  fwd_sel1;
  logic [SEL_W-1:0]  fwd_sel2;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output fwd_en, ext_freeze, flush, id_valid, id_src1, id_src2,
           id_src1_used, id_src2_used, id_wb_en, id_mem_r_en, id_dest,
    input  stall, fwd_sel1, fwd_sel2, stall_cnt
  );

  modport slave (
    input  fwd_en, ext_freeze, flush, id_valid, id_src1, id_src2,
           id_src1_used, id_src2_used, id_wb_en, id_mem_r_en, id_dest,
    output stall, fwd_sel1, fwd_sel2, stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_scoreboard.sv
// rtl/pipe_hazard_scoreboard.sv - shifting scoreboard producing decode stall and EXE forwarding selects
module pipe_hazard_scoreboard #(
  parameter int REG_AW     = 4,
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 2,
  parameter int CNT_W      = 32,
  localparam int SEL_W     = $clog2(DEPTH)
) (
  input logic                    clk,
  input logic                    rst,
  pipe_hazard_scoreboard_if.slave bus
);
  // The oldest entry (DEPTH-1) writes the regfile this cycle and can never match,
  // so only the first DEPTH-1 entries are stored.
  localparam int NE = DEPTH - 1;

  logic [NE-1:0]             v_q, v_d, wb_q, wb_d, ld_q, ld_d;
  logic [NE-1:0][REG_AW-1:0] dest_q, dest_d;
  logic [SEL_W-1:0]          fwd_sel1_q, fwd_sel1_d, fwd_sel2_q, fwd_sel2_d;
  logic [CNT_W-1:0]          stall_cnt_q, stall_cnt_d;

  logic             hit1, hit2, lhaz1, lhaz2, hazard, stall, issue;
  logic [SEL_W-1:0] sel1, sel2;

  always_comb begin
    hit1  = 1'b0;
    hit2  = 1'b0;
    lhaz1 = 1'b0;
    lhaz2 = 1'b0;
    sel1  = '0;
    sel2  = '0;
    // Ascending scan with a first-hit latch keeps the youngest producer.
    for (int k = 0; k < NE; k++) begin
      if (!hit1 && bus.id_src1_used && v_q[k] && wb_q[k] && dest_q[k] == bus.id_src1) begin
        hit1  = 1'b1;
        sel1  = SEL_W'(k + 1);
        lhaz1 = ld_q[k] && (k + 1 < LOAD_STAGE);
      end
      if (!hit2 && bus.id_src2_used && v_q[k] && wb_q[k] && dest_q[k] == bus.id_src2) begin
        hit2  = 1'b1;
        sel2  = SEL_W'(k + 1);
        lhaz2 = ld_q[k] && (k + 1 < LOAD_STAGE);
      end
    end
    hazard = bus.fwd_en ? (lhaz1 || lhaz2) : (hit1 || hit2);
    stall  = bus.id_valid && hazard && !bus.flush;
    issue  = bus.id_valid && !bus.flush && !stall;
  end

  always_comb begin
    v_d         = v_q;
    wb_d        = wb_q;
    ld_d        = ld_q;
    dest_d      = dest_q;
    fwd_sel1_d  = fwd_sel1_q;
    fwd_sel2_d  = fwd_sel2_q;
    stall_cnt_d = stall_cnt_q;
    if (!bus.ext_freeze) begin
      for (int k = NE - 1; k > 0; k--) begin
        v_d[k]    = v_q[k-1];
        wb_d[k]   = wb_q[k-1];
        ld_d[k]   = ld_q[k-1];
        dest_d[k] = dest_q[k-1];
      end
      v_d[0]     = issue;
      wb_d[0]    = bus.id_wb_en;
      ld_d[0]    = bus.id_mem_r_en;
      dest_d[0]  = bus.id_dest;
      fwd_sel1_d = (issue && bus.fwd_en && hit1) ? sel1 : '0;
      fwd_sel2_d = (issue && bus.fwd_en && hit2) ? sel2 : '0;
      if (stall && stall_cnt_q != '1) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_q         <= '0;
      wb_q        <= '0;
      ld_q        <= '0;
      dest_q      <= '0;
      fwd_sel1_q  <= '0;
      fwd_sel2_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      v_q         <= v_d;
      wb_q        <= wb_d;
      ld_q        <= ld_d;
      dest_q      <= dest_d;
      fwd_sel1_q  <= fwd_sel1_d;
      fwd_sel2_q  <= fwd_sel2_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.stall     = stall;
  assign bus.fwd_sel1  = fwd_sel1_q;
  assign bus.fwd_sel2  = fwd_sel2_q;
  assign bus.stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_pipe_hazard_scoreboard.sv
// tb/tb_pipe_hazard_scoreboard.sv - directed checks of stall, forwarding, freeze, flush, reset and saturation
module tb_pipe_hazard_scoreboard;
  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  int   n;

  pipe_hazard_scoreboard_if #(.REG_AW(4), .SEL_W(2), .CNT_W(4)) bus ();

  pipe_hazard_scoreboard #(.REG_AW(4), .DEPTH(3), .LOAD_STAGE(2), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ins(input logic [3:0] dest, input logic wb, input logic ld,
                     input logic [3:0] s1, input logic u1,
                     input logic [3:0] s2, input logic u2);
    bus.id_valid     = 1'b1;
    bus.id_dest      = dest;
    bus.id_wb_en     = wb;
    bus.id_mem_r_en  = ld;
    bus.id_src1      = s1;
    bus.id_src1_used = u1;
    bus.id_src2      = s2;
    bus.id_src2_used = u2;
  endtask

  task automatic drain();
    bus.id_valid     = 1'b0;
    bus.id_src1_used = 1'b0;
    bus.id_src2_used = 1'b0;
    bus.flush        = 1'b0;
    bus.ext_freeze   = 1'b0;
    repeat (3) step();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b0;
    bus.fwd_en = 1'b1;
    bus.ext_freeze = 1'b0;
    bus.flush = 1'b0;
    ins(4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    bus.id_valid = 1'b0;
    #1;
    chk("rst_stall", bus.stall, 0);
    chk("rst_sel1", bus.fwd_sel1, 0);
    chk("rst_cnt", bus.stall_cnt, 0);
    step();
    step();
    rst = 1'b1;

    // 1: ALU producer forwarded from entry 0
    bus.fwd_en = 1'b1;
    ins(4'd1, 1'b1, 1'b0, 4'd2, 1'b1, 4'd3, 1'b1);
    #1 chk("t1_prod_stall", bus.stall, 0);
    step();
    ins(4'd2, 1'b1, 1'b0, 4'd1, 1'b1, 4'd3, 1'b1);
    #1 chk("t1_stall", bus.stall, 0);
    step();
    chk("t1_sel1", bus.fwd_sel1, 1);
    chk("t1_sel2", bus.fwd_sel2, 0);
    drain();

    // 2: load-use, one bubble then forward from entry 1
    ins(4'd1, 1'b1, 1'b1, 4'd4, 1'b1, 4'd0, 1'b0);
    step();
    ins(4'd2, 1'b1, 1'b0, 4'd1, 1'b1, 4'd5, 1'b1);
    #1 chk("t2_stall", bus.stall, 1);
    step();
    chk("t2_bubble_sel1", bus.fwd_sel1, 0);
    chk("t2_stall_off", bus.stall, 0);
    step();
    chk("t2_sel1", bus.fwd_sel1, 2);
    chk("t2_cnt", bus.stall_cnt, 1);
    drain();

    // 3: stall-only mode waits DEPTH-1 cycles
    bus.fwd_en = 1'b0;
    ins(4'd1, 1'b1, 1'b0, 4'd2, 1'b1, 4'd3, 1'b1);
    step();
    ins(4'd4, 1'b1, 1'b0, 4'd1, 1'b1, 4'd1, 1'b1);
    #1;
    n = 0;
    while (bus.stall && n < 6) begin
      n++;
      step();
    end
    chk("t3_stall_cycles", n, 2);
    chk("t3_cnt", bus.stall_cnt, 3);
    step();
    chk("t3_sel1", bus.fwd_sel1, 0);
    chk("t3_sel2", bus.fwd_sel2, 0);
    drain();

    // 4: flush kills the dependent consumer
    bus.fwd_en = 1'b1;
    ins(4'd1, 1'b1, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0);
    step();
    ins(4'd2, 1'b1, 1'b0, 4'd1, 1'b1, 4'd0, 1'b0);
    bus.flush = 1'b1;
    #1 chk("t4_stall", bus.stall, 0);
    step();
    bus.flush = 1'b0;
    ins(4'd5, 1'b1, 1'b0, 4'd2, 1'b1, 4'd2, 1'b1);
    #1 chk("t4_reader_stall", bus.stall, 0);
    step();
    chk("t4_sel1", bus.fwd_sel1, 0);
    chk("t4_sel2", bus.fwd_sel2, 0);
    chk("t4_cnt", bus.stall_cnt, 3);
    drain();

    // 5: freeze holds the scoreboard while stall stays asserted
    bus.fwd_en = 1'b0;
    ins(4'd1, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    step();
    ins(4'd4, 1'b1, 1'b0, 4'd1, 1'b1, 4'd0, 1'b0);
    bus.ext_freeze = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t5_frz_stall", bus.stall, 1);
      chk("t5_frz_cnt", bus.stall_cnt, 3);
    end
    bus.ext_freeze = 1'b0;
    step();
    chk("t5_rel_cnt1", bus.stall_cnt, 4);
    chk("t5_rel_stall1", bus.stall, 1);
    step();
    chk("t5_rel_cnt2", bus.stall_cnt, 5);
    chk("t5_rel_stall2", bus.stall, 0);
    drain();

    // 6: two producers of r1, youngest wins; unused src2 ignored
    bus.fwd_en = 1'b1;
    ins(4'd1, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    step();
    ins(4'd1, 1'b1, 1'b0, 4'd7, 1'b1, 4'd8, 1'b1);
    step();
    ins(4'd3, 1'b1, 1'b0, 4'd1, 1'b1, 4'd1, 1'b0);
    #1 chk("t6_stall", bus.stall, 0);
    step();
    chk("t6_sel1", bus.fwd_sel1, 1);
    chk("t6_sel2", bus.fwd_sel2, 0);
    drain();

    // Counter saturation at 15 (two stall cycles per iteration)
    bus.fwd_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      ins(4'd1, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
      step();
      ins(4'd4, 1'b1, 1'b0, 4'd1, 1'b1, 4'd0, 1'b0);
      repeat (3) step();
      if (i == 3) chk("sat_cnt13", bus.stall_cnt, 13);
      if (i == 4) chk("sat_cnt15", bus.stall_cnt, 15);
    end
    chk("sat_hold", bus.stall_cnt, 15);
    drain();

    // Async reset in the middle of a stall
    bus.fwd_en = 1'b1;
    ins(4'd1, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    step();
    ins(4'd2, 1'b1, 1'b0, 4'd1, 1'b1, 4'd0, 1'b0);
    step();
    chk("rs_sel1_pre", bus.fwd_sel1, 1);
    bus.fwd_en = 1'b0;
    ins(4'd3, 1'b1, 1'b0, 4'd2, 1'b1, 4'd0, 1'b0);
    #1 chk("rs_stall_pre", bus.stall, 1);
    rst = 1'b0;
    #1;
    chk("rs_stall", bus.stall, 0);
    chk("rs_sel1", bus.fwd_sel1, 0);
    chk("rs_cnt", bus.stall_cnt, 0);
    #1 rst = 1'b1;
    #1 chk("rs_stall_after", bus.stall, 0);
    step();
    chk("rs_cnt_after", bus.stall_cnt, 0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
